// File: rtl/m_clk_sw_pkg.sv
// m_clk_sw_pkg: shared definitions for the glitch-free clock switch controller.
//   - state_e     : controller FSM states
//   - CNT_W       : settle counter width (8 bits)
//   - SETTLE_MIN/SETTLE_MAX : legal range of the SETTLE_CYC parameter
//   - settle_load : counter load value for a given SETTLE_CYC (clamped to range)
package m_clk_sw_pkg;

  localparam int CNT_W      = 8;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 255;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_GATE_OFF = 3'd2,
    ST_SWITCH   = 3'd3,
    ST_GATE_ON  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // A phase lasts SETTLE_CYC cycles: the counter is loaded with SETTLE_CYC-1
  // on entry and the phase ends on the cycle it reads zero. Out-of-range
  // values are clamped so the load value always fits the counter.
  function automatic logic [CNT_W-1:0] settle_load(input int settle_cyc);
    int c;
    c = settle_cyc;
    if (c < SETTLE_MIN) c = SETTLE_MIN;
    if (c > SETTLE_MAX) c = SETTLE_MAX;
    return CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/m_clk_sw_cnt.sv
// m_clk_sw_cnt: settle counter for the clock switch controller.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (counter -> RST_VAL)
//   load      : load load_val this cycle (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; saturates at zero (no wrap-around)
//   zero      : counter currently reads zero
module m_clk_sw_cnt
  import m_clk_sw_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/m_clk_sw_ctrl.sv
// m_clk_sw_ctrl: sequencer for a glitch-free switch between two clocks.
// It only drives the select of an external 2:1 clock mux and the enable of
// an external clock gate; no clock passes through this block.
// Ports:
//   clk        : free-running controller clock (all outputs registered)
//   rst        : asynchronous active-high reset; restarts the INIT phase
//   req        : switch request (4-phase handshake with ack)
//   tgt_sel    : requested mux select, sampled when req is accepted
//   ack        : request complete, held until req is seen low
//   busy       : init or switch sequence in progress
//   mux_sel    : select of the downstream clock mux (0 = A, 1 = B)
//   gate_en    : enable of the clock gate after the mux (0 = clock held low)
//   dbg_state  : current FSM state (state_e encoding)
//
// Handshake: a request is accepted in IDLE when req=1 and req was sampled
// low at least once while in IDLE since the last completion or init. ack
// rises when the sequence completes and falls the cycle after req is sampled
// low in DONE. Everything between acceptance and DONE ignores req/tgt_sel.
module m_clk_sw_ctrl
  import m_clk_sw_pkg::*;
#(
  parameter int   SETTLE_CYC = 4,
  parameter logic RST_SEL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       tgt_sel,
  output logic       ack,
  output logic       busy,
  output logic       mux_sel,
  output logic       gate_en,
  output logic [2:0] dbg_state
);

  localparam logic [CNT_W-1:0] LOAD_VAL = settle_load(SETTLE_CYC);

  state_e state_q, state_d;
  logic   ack_q, ack_d;
  logic   busy_q, busy_d;
  logic   mux_q, mux_d;
  logic   gate_q, gate_d;
  logic   armed_q, armed_d;   // req has been seen low in IDLE
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  // The counter's reset value covers the INIT phase entry, since reset is
  // the only way into INIT.
  m_clk_sw_cnt #(
    .RST_VAL (LOAD_VAL)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    mux_d    = mux_q;
    gate_d   = gate_q;
    armed_d  = armed_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_IDLE;
          gate_d  = 1'b1;
          busy_d  = 1'b0;
          armed_d = 1'b0;
        end
      end

      ST_IDLE: begin
        if (!req) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          if (tgt_sel != mux_q) begin
            state_d  = ST_GATE_OFF;
            gate_d   = 1'b0;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
          end
        end
      end

      ST_GATE_OFF: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          // A sequence is only started when the target differs from the
          // current select, so inverting it reaches the target latched at
          // acceptance regardless of later tgt_sel activity.
          state_d  = ST_SWITCH;
          mux_d    = ~mux_q;
          cnt_load = 1'b1;
        end
      end

      ST_SWITCH: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d  = ST_GATE_ON;
          gate_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end

      ST_GATE_ON: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end

      ST_DONE: begin
        if (req) begin
          ack_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          armed_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      mux_q   <= RST_SEL;
      gate_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      mux_q   <= mux_d;
      gate_q  <= gate_d;
      armed_q <= armed_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign mux_sel   = mux_q;
  assign gate_en   = gate_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_m_clk_sw_ctrl.sv
// tb_m_clk_sw_ctrl: directed bench for m_clk_sw_ctrl (SETTLE_CYC=4, RST_SEL=0).
// Stimulus pushes each expected output change as {cycle, ack, busy, mux_sel,
// gate_en} into exp_q; the monitor pops an entry whenever the output vector
// changes and compares value and cycle. A separate checker watches the
// spacing between mux_sel changes and gate_en edges.
module tb_m_clk_sw_ctrl;

  localparam int SETTLE = 4;
  localparam int W      = 20;

  logic       clk;
  logic       rst;
  logic       req;
  logic       tgt_sel;
  logic       ack;
  logic       busy;
  logic       mux_sel;
  logic       gate_en;
  logic [2:0] dbg_state;

  logic [15:0]  cyc;
  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_bad;
  event         probe;

  m_clk_sw_ctrl #(
    .SETTLE_CYC (SETTLE),
    .RST_SEL    (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tgt_sel   (tgt_sel),
    .ack       (ack),
    .busy      (busy),
    .mux_sel   (mux_sel),
    .gate_en   (gate_en),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // expected outputs {ack,busy,mux_sel,gate_en} appear off cycles from now
  task automatic expect_at(input int off, input logic [3:0] v);
    exp_q.push_back({16'(int'(cyc) + off), v});
  endtask

  task automatic drive_req(input logic r, input logic t);
    req     = r;
    tgt_sel = t;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [3:0] prev_out;
  initial prev_out = 4'bxxxx;

  always begin
    logic [3:0]   cur;
    logic [W-1:0] e;
    @(negedge clk or probe);
    cur = {ack, busy, mux_sel, gate_en};
    if (cur !== prev_out) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change: got cyc=%0d out=%b, required no change", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e !== {cyc, cur}) begin
          n_bad++;
          $display("FAIL event: got cyc=%0d out=%b, required cyc=%0d out=%b",
                   cyc, cur, e[W-1:4], e[3:0]);
        end
      end
      prev_out = cur;
    end
  end

  // ---------------- mux/gate spacing checker ----------------
  logic mux_prev;
  logic gate_prev;
  int   gate_fall_cyc;
  int   mux_chg_cyc;
  initial begin
    mux_prev      = 1'b0;
    gate_prev     = 1'b0;
    gate_fall_cyc = 0;
    mux_chg_cyc   = -1000;
  end

  always @(negedge clk) begin
    if (mux_sel !== mux_prev) begin
      n_vec++;
      if (gate_en !== 1'b0 || (int'(cyc) - gate_fall_cyc) < SETTLE) begin
        n_bad++;
        $display("FAIL mux_spacing: got mux change at cyc=%0d gate_en=%b fall_cyc=%0d, required gate_en=0 for %0d cycles",
                 cyc, gate_en, gate_fall_cyc, SETTLE);
      end
      mux_chg_cyc = int'(cyc);
    end
    if (gate_en === 1'b1 && gate_prev === 1'b0) begin
      n_vec++;
      if ((int'(cyc) - mux_chg_cyc) < SETTLE) begin
        n_bad++;
        $display("FAIL gate_spacing: got gate_en rise at cyc=%0d mux change cyc=%0d, required %0d cycles apart",
                 cyc, mux_chg_cyc, SETTLE);
      end
    end
    if (gate_en === 1'b0 && gate_prev === 1'b1) gate_fall_cyc = int'(cyc);
    mux_prev  = mux_sel;
    gate_prev = gate_en;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [W-1:0] e;
    n_vec   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    req     = 1'b0;
    tgt_sel = 1'b0;

    // reset values, then INIT holds the gate off for SETTLE cycles
    expect_at(1, 4'b0100);
    cycles(3);
    rst = 1'b0;
    expect_at(4, 4'b0001);
    cycles(8);

    // full switch 0 -> 1
    drive_req(1'b1, 1'b1);
    expect_at(1,  4'b0100);
    expect_at(5,  4'b0110);
    expect_at(9,  4'b0111);
    expect_at(13, 4'b1011);
    cycles(14);
    drive_req(1'b0, 1'b1);
    expect_at(1, 4'b0011);
    cycles(3);

    // target equals current select: immediate ack, clock untouched
    drive_req(1'b1, 1'b1);
    expect_at(1, 4'b1011);
    cycles(3);
    drive_req(1'b0, 1'b1);
    expect_at(1, 4'b0011);

    // req raised again right after completion, without a low cycle in IDLE:
    // not accepted until req is dropped and raised again
    cycles(1);
    drive_req(1'b1, 1'b1);
    cycles(4);
    drive_req(1'b0, 1'b1);
    cycles(1);
    drive_req(1'b1, 1'b1);
    expect_at(1, 4'b1011);
    cycles(2);
    drive_req(1'b0, 1'b1);
    expect_at(1, 4'b0011);
    cycles(3);

    // switch 1 -> 0; at t+3 tgt_sel toggles and req drops
    drive_req(1'b1, 1'b0);
    expect_at(1,  4'b0110);
    expect_at(5,  4'b0100);
    expect_at(9,  4'b0101);
    expect_at(13, 4'b1001);
    expect_at(14, 4'b0001);
    cycles(3);
    drive_req(1'b0, 1'b1);
    cycles(16);

    // switch 0 -> 1 aborted by reset at t+6, after the mux flip
    drive_req(1'b1, 1'b1);
    expect_at(1, 4'b0100);
    expect_at(5, 4'b0110);
    cycles(6);
    #2;
    rst = 1'b1;
    req = 1'b0;
    expect_at(0, 4'b0100);
    #1;
    -> probe;
    cycles(2);
    rst = 1'b0;
    expect_at(4, 4'b0001);
    cycles(10);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_event: got no change, required cyc=%0d out=%b", e[W-1:4], e[3:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
